// File: rtl/rggen_bit_field_pulse_source.sv
// Software-loaded pulse emitter: a written count N is paid out as N valid/ready
// events, decrementing the field once per accepted event.
module rggen_bit_field_pulse_source #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = {WIDTH{1'b0}},
  parameter int               GAP_WIDTH     = 4,
  parameter bit               USE_ABORT     = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_sw_write_valid,
  input  logic                 i_sw_read_valid,
  input  logic [WIDTH-1:0]     i_sw_mask,
  input  logic [WIDTH-1:0]     i_sw_write_data,
  output logic [WIDTH-1:0]     o_sw_read_data,
  output logic [WIDTH-1:0]     o_sw_value,
  input  logic [GAP_WIDTH-1:0] i_gap,
  input  logic                 i_abort,
  output logic                 o_pulse,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     remaining_q, remaining_d;
  logic [GAP_WIDTH-1:0] gap_q, gap_d;
  logic                 done_q, done_d;

  logic                 handshake;
  logic                 abort;
  logic                 last_pulse;
  logic [WIDTH-1:0]     sw_merged;
  logic                 unused_sw_read;

  // Reads are side-effect free, so the strobe is intentionally not consumed.
  assign unused_sw_read = i_sw_read_valid;

  assign handshake  = (state_q == SEND) && i_ready;
  assign abort      = USE_ABORT && i_abort;
  assign sw_merged  = (remaining_q & ~i_sw_mask) | (i_sw_write_data & i_sw_mask);
  // A software write in the handshake cycle suppresses the decrement, so that
  // pulse cannot be the final one.
  assign last_pulse = (remaining_q == WIDTH'(1)) && !i_sw_write_valid;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (remaining_q != '0) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (last_pulse) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (i_gap != '0) begin
            state_d = GAP;
            gap_d   = i_gap;
          end
        end
      end
      GAP: begin
        if (remaining_q == '0) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - GAP_WIDTH'(1);
          if (gap_q == GAP_WIDTH'(1)) begin
            state_d = SEND;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = '0;
      end
    endcase

    if (handshake) begin
      remaining_d = remaining_q - WIDTH'(1);
    end

    if (i_sw_write_valid) begin
      remaining_d = sw_merged;
      if (sw_merged == '0) begin
        state_d = IDLE;
        gap_d   = '0;
        done_d  = 1'b0;
      end
    end

    if (abort) begin
      remaining_d = '0;
      state_d     = IDLE;
      gap_d       = '0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      remaining_q <= INITIAL_VALUE;
      gap_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      done_q      <= done_d;
    end
  end

  assign o_pulse        = (state_q == SEND);
  assign o_busy         = (state_q != IDLE);
  assign o_done         = done_q;
  assign o_sw_read_data = remaining_q;
  assign o_sw_value     = remaining_q;

endmodule

// File: tb/tb_rggen_bit_field_pulse_source.sv
// Directed bench for the pulse source: two instances, one with a zero power-up
// count driven by software, one preloaded with a count of 2.
module tb_rggen_bit_field_pulse_source;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_wr = 1'b0;
  logic       sw_rd = 1'b0;
  logic [7:0] sw_mask = 8'h00;
  logic [7:0] sw_wdata = 8'h00;
  logic [7:0] rdata, value;
  logic [3:0] gap = 4'd0;
  logic       abort = 1'b0;
  logic       pulse, ready = 1'b0, busy, done;

  logic       rst2_n = 1'b0;
  logic [7:0] rdata2, value2;
  logic       pulse2, busy2, done2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rggen_bit_field_pulse_source #(
    .WIDTH(8), .INITIAL_VALUE(8'h00), .GAP_WIDTH(4), .USE_ABORT(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_sw_write_valid(sw_wr), .i_sw_read_valid(sw_rd),
    .i_sw_mask(sw_mask), .i_sw_write_data(sw_wdata),
    .o_sw_read_data(rdata), .o_sw_value(value),
    .i_gap(gap), .i_abort(abort),
    .o_pulse(pulse), .i_ready(ready), .o_busy(busy), .o_done(done)
  );

  rggen_bit_field_pulse_source #(
    .WIDTH(8), .INITIAL_VALUE(8'h02), .GAP_WIDTH(4), .USE_ABORT(1)
  ) dut2 (
    .i_clk(clk), .i_rst_n(rst2_n),
    .i_sw_write_valid(1'b0), .i_sw_read_valid(1'b0),
    .i_sw_mask(8'h00), .i_sw_write_data(8'h00),
    .o_sw_read_data(rdata2), .o_sw_value(value2),
    .i_gap(4'd0), .i_abort(1'b0),
    .o_pulse(pulse2), .i_ready(1'b1), .o_busy(busy2), .o_done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sw_write(input logic [7:0] data, input logic [7:0] mask);
    sw_wr    = 1'b1;
    sw_wdata = data;
    sw_mask  = mask;
    tick();
    sw_wr    = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_read", {24'd0, rdata}, 32'h00);
    check("rst_value", {24'd0, value}, 32'h00);
    check("rst_pulse", {31'd0, pulse}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst2_value", {24'd0, value2}, 32'h02);
    check("rst2_pulse", {31'd0, pulse2}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_pulse", {31'd0, pulse}, 32'd0);

    // Count of 3, no gap, always ready.
    gap = 4'd0; ready = 1'b1;
    sw_write(8'd3, 8'hFF);
    check("t1_load", {24'd0, rdata}, 32'd3);
    check("t1_load_pulse", {31'd0, pulse}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t1_pulse%0d", i), {31'd0, pulse}, 32'd1);
      check($sformatf("t1_read%0d", i), {24'd0, rdata}, 32'(3 - i));
    end
    tick();
    check("t1_end_pulse", {31'd0, pulse}, 32'd0);
    check("t1_end_read", {24'd0, rdata}, 32'd0);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);
    tick();
    check("t1_done_clr", {31'd0, done}, 32'd0);

    // Count of 2 with a 4-cycle gap.
    gap = 4'd4;
    sw_write(8'd2, 8'hFF);
    tick();
    check("t2_p1", {31'd0, pulse}, 32'd1);
    check("t2_p1_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t2_gap%0d", i), {31'd0, pulse}, 32'd0);
      check($sformatf("t2_gapbusy%0d", i), {31'd0, busy}, 32'd1);
    end
    check("t2_gap_read", {24'd0, rdata}, 32'd1);
    tick();
    check("t2_p2", {31'd0, pulse}, 32'd1);
    tick();
    check("t2_end_pulse", {31'd0, pulse}, 32'd0);
    check("t2_end_busy", {31'd0, busy}, 32'd0);
    check("t2_done", {31'd0, done}, 32'd1);
    gap = 4'd0;

    // Count of 1 with downstream stalled.
    ready = 1'b0;
    tick();
    sw_write(8'd1, 8'hFF);
    for (int i = 0; i < 11; i++) begin
      tick();
      check($sformatf("t3_hold%0d", i), {31'd0, pulse}, 32'd1);
      check($sformatf("t3_cnt%0d", i), {24'd0, rdata}, 32'd1);
      check($sformatf("t3_nodone%0d", i), {31'd0, done}, 32'd0);
    end
    ready = 1'b1;
    tick();
    check("t3_end_pulse", {31'd0, pulse}, 32'd0);
    check("t3_end_read", {24'd0, rdata}, 32'd0);
    check("t3_done", {31'd0, done}, 32'd1);
    tick();
    check("t3_done_clr", {31'd0, done}, 32'd0);

    // Count of 5, abort after two accepted pulses.
    sw_write(8'd5, 8'hFF);
    tick();
    tick();
    tick();
    check("t4_pre_read", {24'd0, rdata}, 32'd3);
    check("t4_pre_pulse", {31'd0, pulse}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_pulse", {31'd0, pulse}, 32'd0);
    check("t4_abort_read", {24'd0, rdata}, 32'd0);
    check("t4_abort_busy", {31'd0, busy}, 32'd0);
    check("t4_abort_done", {31'd0, done}, 32'd0);
    tick();
    check("t4_abort_done2", {31'd0, done}, 32'd0);
    sw_write(8'd1, 8'hFF);
    tick();
    check("t4_restart_pulse", {31'd0, pulse}, 32'd1);
    tick();
    check("t4_restart_done", {31'd0, done}, 32'd1);

    // Masked write during an accepted handshake, then a zero write in SEND.
    sw_write(8'h12, 8'hFF);
    tick();
    check("t5_pulse", {31'd0, pulse}, 32'd1);
    check("t5_pre_read", {24'd0, rdata}, 32'h12);
    sw_write(8'hFF, 8'h0F);
    check("t5_merge_read", {24'd0, rdata}, 32'h1F);
    check("t5_merge_pulse", {31'd0, pulse}, 32'd1);
    tick();
    check("t5_dec_read", {24'd0, rdata}, 32'h1E);
    check("t5_dec_pulse", {31'd0, pulse}, 32'd1);
    sw_write(8'h00, 8'hFF);
    check("t5_zero_pulse", {31'd0, pulse}, 32'd0);
    check("t5_zero_busy", {31'd0, busy}, 32'd0);
    check("t5_zero_read", {24'd0, rdata}, 32'h00);
    check("t5_zero_done", {31'd0, done}, 32'd0);
    tick();
    check("t5_zero_done2", {31'd0, done}, 32'd0);

    // Asynchronous reset mid-operation.
    sw_write(8'd4, 8'hFF);
    tick();
    check("t6_pulse", {31'd0, pulse}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_pulse", {31'd0, pulse}, 32'd0);
    check("t6_async_read", {24'd0, rdata}, 32'd0);
    check("t6_async_busy", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Preloaded instance released from reset.
    rst2_n = 1'b1;
    check("t7_rel_pulse", {31'd0, pulse2}, 32'd0);
    check("t7_rel_read", {24'd0, rdata2}, 32'd2);
    tick();
    check("t7_p1", {31'd0, pulse2}, 32'd1);
    check("t7_p1_read", {24'd0, rdata2}, 32'd2);
    tick();
    check("t7_p2", {31'd0, pulse2}, 32'd1);
    check("t7_p2_read", {24'd0, rdata2}, 32'd1);
    tick();
    check("t7_end_pulse", {31'd0, pulse2}, 32'd0);
    check("t7_done", {31'd0, done2}, 32'd1);
    check("t7_end_read", {24'd0, rdata2}, 32'd0);
    tick();
    check("t7_done_clr", {31'd0, done2}, 32'd0);
    check("t7_idle_busy", {31'd0, busy2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
